// File: rtl/uart_pkg.sv
// Shared types, widths and helpers for the UART transmit arbitration path.
package uart_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF = 4;

  // Index width for a requester count; never narrower than one bit.
  function automatic int gid_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Width that can hold 0..max_val inclusive; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int GID_W = gid_width(NUM_REQ_DEF);

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// last_grant, wrapping modulo NUM_REQ (last_grant itself is checked last).
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = GID_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  // base is always < NUM_REQ and ofs <= NUM_REQ, so one subtraction wraps.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[wrap_idx(last_grant, k)]) begin
        found = 1'b1;
        index = wrap_idx(last_grant, k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX byte stream among
// NUM_REQ requesters; releases on last byte, burst limit or idle timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [gid_width(NUM_REQ)-1:0] grant_id,
  output logic                          busy
);

  localparam int GW = gid_width(NUM_REQ);
  localparam int IW = cnt_width(IDLE_TIMEOUT);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_LOCK = LOCK;

  logic [0:0]    state_reg;
  logic [GW-1:0] grant_id_reg;
  logic [GW-1:0] last_grant_reg;
  logic [7:0]    burst_cnt_reg;
  logic [IW-1:0] idle_cnt_reg;

  logic          pick_found;
  logic [GW-1:0] pick_idx;

  logic [NUM_REQ-1:0] gnt_onehot;
  logic               in_lock;
  logic               sel_valid;
  logic               sel_last;
  logic               xfer;
  logic [8:0]         burst_inc;
  logic               burst_hit;
  logic [IW:0]        idle_inc;
  logic [IW-1:0]      idle_sat_next;
  logic               timeout_hit;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .found      (pick_found),
    .index      (pick_idx)
  );

  // rstn gates the pass-through so a byte presented during reset is never accepted.
  assign in_lock = rstn && (state_reg == ST_LOCK);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign gnt_onehot[gi] = (grant_id_reg == GW'(gi));
      assign req_ready[gi]  = in_lock && out_ready && gnt_onehot[gi];
    end
  endgenerate

  assign sel_valid = |(req_valid & gnt_onehot);
  assign sel_last  = |(req_last & gnt_onehot);
  assign out_data  = req_data[int'(grant_id_reg)*DATA_WIDTH +: DATA_WIDTH];
  assign out_valid = in_lock && sel_valid;
  assign xfer      = out_valid && out_ready;

  assign burst_inc     = {1'b0, burst_cnt_reg} + 9'd1;
  assign burst_hit     = (burst_inc == 9'(MAX_BURST));
  assign idle_inc      = {1'b0, idle_cnt_reg} + (IW+1)'(1);
  assign idle_sat_next = (&idle_cnt_reg) ? idle_cnt_reg : idle_inc[IW-1:0];
  assign timeout_hit   = (IDLE_TIMEOUT != 0) && (idle_inc == (IW+1)'(IDLE_TIMEOUT));

  assign grant_id = grant_id_reg;
  assign busy     = (state_reg == ST_LOCK);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      grant_id_reg   <= '0;
      last_grant_reg <= GW'(NUM_REQ - 1);
      burst_cnt_reg  <= '0;
      idle_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id_reg  <= pick_idx;
            burst_cnt_reg <= '0;
            idle_cnt_reg  <= '0;
            state_reg     <= ST_LOCK;
          end
        end
        default: begin
          if (xfer) begin
            burst_cnt_reg <= burst_inc[7:0];
            idle_cnt_reg  <= '0;
            if (sel_last || burst_hit) begin
              last_grant_reg <= grant_id_reg;
              state_reg      <= ST_IDLE;
            end
          end else if (!sel_valid) begin
            // Backpressure with valid high takes neither branch: counters hold.
            idle_cnt_reg <= idle_sat_next;
            if (timeout_hit) begin
              last_grant_reg <= grant_id_reg;
              state_reg      <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte scoreboard and per-requester source queues.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready = 1'b1;
  logic [1:0]       grant_id;
  logic             busy;

  beat_t src_q[NR][$];
  exp_t  exp_q[$];
  int    vectors = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (3)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int id, input logic [7:0] d, input logic last, input bit expd);
    beat_t b;
    exp_t  e;
    b.d = d;
    b.last = last;
    src_q[id].push_back(b);
    if (expd) begin
      e.id = 2'(id);
      e.d = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_last[i] = src_q[i][0].last;
        req_data[i*DW +: DW] = src_q[i][0].d;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask

  // Requesters retire a beat on their own handshake; the scoreboard checks every output beat.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rstn && out_valid && out_ready) begin
      chk("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("beat: id=%0d data=%02h (expected id=%0d data=%02h)", grant_id, out_data, e.id, e.d);
        chk("beat_id", 32'(grant_id), 32'(e.id));
        chk("beat_data", 32'(out_data), 32'(e.d));
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[5];
    seq = '{0, 1, 2, 3, 0};

    // Reset values
    drive();
    repeat (3) cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rstn = 1'b1;
    cyc();
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Single packet from requester 2
    beat(2, 8'h41, 1'b0, 1'b1);
    beat(2, 8'h42, 1'b0, 1'b1);
    beat(2, 8'h43, 1'b1, 1'b1);
    drive();
    #1;
    chk("single_idle_valid", 32'(out_valid), 32'd0);
    chk("single_idle_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_grant", 32'(grant_id), 32'd2);
    chk("single_d0", 32'(out_data), 32'h41);
    cyc();
    chk("single_d1", 32'(out_data), 32'h42);
    cyc();
    chk("single_d2", 32'(out_data), 32'h43);
    cyc();
    chk("single_release", 32'(busy), 32'd0);
    chk("single_grant_hold", 32'(grant_id), 32'd2);
    chk("single_done", 32'(exp_q.size()), 32'd0);
    cyc();

    // Reset in the middle of a 4-byte packet from requester 2
    for (int i = 0; i < 4; i++) beat(2, 8'hC1 + 8'(i), (i == 3), (i == 0));
    drive();
    cyc();
    chk("rmid_grant", 32'(grant_id), 32'd2);
    cyc();
    chk("rmid_d1", 32'(out_data), 32'hC2);
    rstn = 1'b0;
    #1;
    chk("rmid_valid_gated", 32'(out_valid), 32'd0);
    chk("rmid_ready_gated", 32'(req_ready), 32'd0);
    cyc();
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_grant0", 32'(grant_id), 32'd0);
    chk("rmid_valid", 32'(out_valid), 32'd0);
    chk("rmid_ready", 32'(req_ready), 32'd0);
    src_q[2].delete();
    rstn = 1'b1;
    beat(3, 8'hD3, 1'b1, 1'b0);
    beat(0, 8'hD0, 1'b1, 1'b1);
    exp_q.push_back('{id: 2'd3, d: 8'hD3});
    drive();
    #1;
    cyc();
    chk("rmid_prio0", 32'(grant_id), 32'd0);
    cyc();
    cyc();
    chk("rmid_then3", 32'(grant_id), 32'd3);
    cyc();
    chk("rmid_done", 32'(exp_q.size()), 32'd0);

    // Contention: all four valid, requester 0 has two packets
    beat(0, 8'hA0, 1'b1, 1'b1);
    beat(1, 8'hA1, 1'b1, 1'b1);
    beat(2, 8'hA2, 1'b1, 1'b1);
    beat(3, 8'hA3, 1'b1, 1'b1);
    beat(0, 8'hA4, 1'b1, 1'b1);
    drive();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("cont_busy", 32'(busy), 32'(k % 2));
      if (k % 2 == 1) chk("cont_grant", 32'(grant_id), 32'(seq[(k-1)/2]));
    end
    chk("cont_done", 32'(exp_q.size()), 32'd0);

    // Burst limit 4: requester 1 streams 10 bytes, requester 3 sends a 2-byte packet
    for (int i = 0; i < 10; i++) beat(1, 8'h10 + 8'(i), 1'b0, (i < 4));
    beat(3, 8'hB0, 1'b0, 1'b0);
    beat(3, 8'hB1, 1'b1, 1'b0);
    exp_q.push_back('{id: 2'd3, d: 8'hB0});
    exp_q.push_back('{id: 2'd3, d: 8'hB1});
    for (int i = 4; i < 10; i++) exp_q.push_back('{id: 2'd1, d: 8'h10 + 8'(i)});
    drive();
    for (int k = 0; k < 80 && !(exp_q.size() == 0 && !busy); k++) cyc();
    chk("burst_drained", 32'(exp_q.size()), 32'd0);
    chk("burst_idle", 32'(busy), 32'd0);

    // Backpressure: data held, req_ready follows out_ready, no timeout
    beat(0, 8'h55, 1'b0, 1'b1);
    beat(0, 8'h66, 1'b1, 1'b1);
    drive();
    cyc();
    chk("bp_grant", 32'(grant_id), 32'd0);
    chk("bp_ready1", 32'(req_ready), 32'h1);
    cyc();
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_hold", 32'(out_data), 32'h66);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_back", 32'(req_ready), 32'h1);
    cyc();
    chk("bp_release", 32'(busy), 32'd0);
    chk("bp_done", 32'(exp_q.size()), 32'd0);

    // Idle timeout of 3 cycles, requester 1 pending
    beat(0, 8'h77, 1'b0, 1'b1);
    drive();
    cyc();
    chk("to_grant0", 32'(grant_id), 32'd0);
    beat(1, 8'h88, 1'b1, 1'b1);
    drive();
    cyc();
    chk("to_idle1", 32'(busy), 32'd1);
    cyc();
    chk("to_idle2", 32'(busy), 32'd1);
    cyc();
    chk("to_idle3", 32'(busy), 32'd1);
    cyc();
    chk("to_revoked", 32'(busy), 32'd0);
    cyc();
    chk("to_next_grant", 32'(grant_id), 32'd1);
    chk("to_next_data", 32'(out_data), 32'h88);
    cyc();
    chk("to_done", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit byte stream among NUM_REQ requesters, such as a debug console, a status reporter and a command-response engine.
- Sits upstream of the TX buffer/FIFO/serializer path and drives its valid/ready byte input.
- Grants are round-robin and packet-locked: a granted requester keeps the line until it marks the last byte, hits the burst limit, or times out idle.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, byte width of each requester and of the output
MAX_BURST, 16, maximum beats per grant before forced rotation (1..255)
IDLE_TIMEOUT, 255, cycles the granted requester may hold valid low before its grant is revoked; 0 disables

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_last  in  NUM_REQ  per-requester last-byte-of-packet flag, qualified by req_valid
req_data  in  NUM_REQ*DATA_WIDTH  packed bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-requester accept
out_valid  out  1  byte valid toward the TX path
out_data  out  DATA_WIDTH  byte toward the TX path
out_ready  in  1  TX path accept
grant_id  out  clog2(NUM_REQ)  index of current or most recent grantee
busy  out  1  high while in LOCK

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rstn.
- Reset values: state = IDLE; out_valid = 0; req_ready = 0; grant_id = 0; busy = 0; burst_cnt = 0; idle_cnt = 0; last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
- Transfer: a beat transfers when out_valid && out_ready. That is the only event that advances burst_cnt.
- State IDLE:
  - out_valid = 0 and all req_ready = 0.
  - If any req_valid is high, the grantee is the first asserted index searching upward from last_grant+1, mod NUM_REQ.
  - Register grantee into grant_id, clear both counters, go to LOCK.
  - Arbitration latency is exactly 1 cycle (IDLE to LOCK). No byte is accepted in IDLE.
- State LOCK, with g = grant_id:
  - out_valid = req_valid[g], out_data = req_data[g], req_ready[g] = out_ready. These are combinational pass-through, so no added latency per beat.
  - req_ready of all other requesters = 0.
  - On a transfer:
    - burst_cnt increments and idle_cnt clears.
    - If req_last[g] is set, or burst_cnt+1 == MAX_BURST, then last_grant = g and the next state is IDLE.
  - If req_valid[g] is low:
    - idle_cnt increments, saturating.
    - If IDLE_TIMEOUT != 0 and idle_cnt+1 == IDLE_TIMEOUT, then last_grant = g and the next state is IDLE. Revocation is silent; there is no error output.
  - If req_valid[g] is high but out_ready is low (backpressure), both counters hold. Backpressure never causes a timeout.
- Rotation: after any release, the next grant goes to the next asserted requester after g. If only g is asserted, g is re-granted after 1 IDLE cycle.
- busy = (state == LOCK). grant_id holds its value in IDLE.
- Simultaneous events: last beat and timeout in the same cycle cannot both occur, because a transfer requires valid. Last beat coincident with burst limit gives a single release.
- Requesters must hold req_data/req_last stable while req_valid is high and req_ready is low. The arbiter does not check this.
- Reset mid-packet: rstn low in any cycle returns to IDLE next edge with all reset values. A byte presented in that cycle is not transferred downstream, and its req_ready is forced 0.
- Width rules:
  - burst_cnt is 8 bits and idle_cnt is clog2(IDLE_TIMEOUT+1) bits (minimum 1).
  - Comparisons are unsigned.
  - Round-robin index arithmetic wraps mod NUM_REQ, with no out-of-range index for non-power-of-2 NUM_REQ.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, LOCK}
  - localparam GID_W = clog2(NUM_REQ)
  - the counter-width function
- One natural sub-module, uart_rr_pick: purely combinational. Inputs req vector and last_grant; outputs found and index. It is reused by later RX dispatch work.
- The FSM, counters and muxing stay in uart_tx_arbiter.

Test Plan:
- Single packet: requester 2 sends 3 bytes 0x41,0x42,0x43 with last on the 3rd, out_ready=1 -> grant_id=2 one cycle after req_valid[2]; bytes appear on consecutive cycles; busy drops the cycle after 0x43; IDLE for 1 cycle.
- Contention: all 4 requesters valid from reset, each sending a 1-byte packet with last=1 -> grants in order 0,1,2,3,0. Each grant gives 1 byte, with 1 IDLE cycle between grants.
- Burst limit: MAX_BURST=4; requester 1 streams 10 bytes with no last, requester 3 also valid -> 4 bytes from 1, then 3's packet, then 1 resumes with byte 5. No byte lost or duplicated.
- Backpressure: out_ready toggles 1,0,0,1 during a 2-byte packet -> req_ready tracks out_ready exactly; the data byte is held; no timeout even with IDLE_TIMEOUT=2.
- Timeout: IDLE_TIMEOUT=3; requester 0 sends 1 byte without last, then drops valid -> release after exactly 3 idle cycles; requester 1, pending, is granted next.
- Reset mid-packet: rstn low during the 2nd byte of a 4-byte packet -> next cycle out_valid=0, req_ready=0, grant_id=0, busy=0. After release, requester 0 has top priority.
